// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline memory stage.
package mips_pipe_pkg;

   typedef enum logic {MS_IDLE, MS_WAIT} mem_state_t;

   localparam int unsigned BYTE_LANES      = 4;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte and sign-extends it for lb,
// passes the full word through for lw.
module load_align
   import mips_pipe_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_is_byte,
   output logic [31:0] o_data
);

   localparam int unsigned LANE_W = 32 / BYTE_LANES;

   logic [LANE_W-1:0] w_byte;

   always_comb begin
      // Little-endian: address offset 0 selects bits [7:0].
      w_byte = i_rdata[i_addr_lo * LANE_W +: LANE_W];
      if (i_is_byte) begin
         o_data = {{(32 - LANE_W){w_byte[LANE_W-1]}}, w_byte};
      end else begin
         o_data = i_rdata;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access stage with req/ready handshake, stall generation, wait timeout
// and the MEM/WB pipeline register.
module mem_wb_stage
   import mips_pipe_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead_MEM,
   input  logic        MemWrite_MEM,
   input  logic [31:0] ALUOut_MEM,
   input  logic [4:0]  Rw_MEM,
   input  logic        MemtoReg_MEM,
   input  logic        RegWrite_MEM,
   input  logic [31:0] rt_MEM,
   input  logic        LoadByte_MEM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic [31:0] ALUOut_WB,
   output logic [31:0] MemData_WB,
   output logic [4:0]  Rw_WB,
   output logic        MemtoReg_WB,
   output logic        RegWrite_WB,
   output logic        misalign_err,
   output logic        timeout_err
);

   localparam int unsigned      CNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   mem_state_t       r_state;
   mem_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   logic        w_mem_op;
   logic        w_misalign;
   logic        w_access;
   logic        w_done;
   logic        w_timeout_now;
   logic [31:0] w_load_data;

   assign w_mem_op   = MemRead_MEM | MemWrite_MEM;
   assign w_misalign = w_mem_op & ~LoadByte_MEM & (ALUOut_MEM[1:0] != 2'b00);
   assign w_access   = w_mem_op & ~w_misalign;

   // Gated by reset so an in-flight request is withdrawn asynchronously.
   assign mem_req       = reset & w_access;
   assign w_done        = mem_req & mem_ready;
   assign w_timeout_now = reset & (r_state == MS_WAIT) & (r_cnt == MAX_CNT) & ~mem_ready;
   assign stall         = reset & w_access & ~w_done & ~w_timeout_now;

   assign mem_we    = MemWrite_MEM;
   assign mem_addr  = ALUOut_MEM & WORD_ALIGN_MASK;
   assign mem_wdata = rt_MEM;

   load_align u_load_align (
      .i_rdata   (mem_rdata),
      .i_addr_lo (ALUOut_MEM[1:0]),
      .i_is_byte (LoadByte_MEM),
      .o_data    (w_load_data)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         MS_IDLE: begin
            if (w_access && !mem_ready) begin
               w_state_nxt = MS_WAIT;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         MS_WAIT: begin
            // Also leave WAIT if the access vanished, so the FSM never sticks.
            if (w_done || w_timeout_now || !w_access) begin
               w_state_nxt = MS_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = MS_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= MS_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ALUOut_WB    <= '0;
         MemData_WB   <= '0;
         Rw_WB        <= '0;
         MemtoReg_WB  <= 1'b0;
         RegWrite_WB  <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         misalign_err <= w_misalign;
         timeout_err  <= w_timeout_now;
         if (stall) begin
            MemtoReg_WB <= 1'b0;
            RegWrite_WB <= 1'b0;
         end else begin
            ALUOut_WB   <= ALUOut_MEM;
            Rw_WB       <= Rw_MEM;
            MemtoReg_WB <= MemtoReg_MEM;
            RegWrite_WB <= RegWrite_MEM & ~w_misalign & ~w_timeout_now;
            MemData_WB  <= (MemRead_MEM && w_access) ? w_load_data : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: one task per scenario with inline checks.
module tb_mem_wb_stage;

   logic        clk;
   logic        reset;
   logic        MemRead_MEM;
   logic        MemWrite_MEM;
   logic [31:0] ALUOut_MEM;
   logic [4:0]  Rw_MEM;
   logic        MemtoReg_MEM;
   logic        RegWrite_MEM;
   logic [31:0] rt_MEM;
   logic        LoadByte_MEM;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        stall;
   logic [31:0] ALUOut_WB;
   logic [31:0] MemData_WB;
   logic [4:0]  Rw_WB;
   logic        MemtoReg_WB;
   logic        RegWrite_WB;
   logic        misalign_err;
   logic        timeout_err;

   int n_pass;
   int n_total;

   mem_wb_stage #(.MAX_WAIT(15)) dut (
      .clk          (clk),
      .reset        (reset),
      .MemRead_MEM  (MemRead_MEM),
      .MemWrite_MEM (MemWrite_MEM),
      .ALUOut_MEM   (ALUOut_MEM),
      .Rw_MEM       (Rw_MEM),
      .MemtoReg_MEM (MemtoReg_MEM),
      .RegWrite_MEM (RegWrite_MEM),
      .rt_MEM       (rt_MEM),
      .LoadByte_MEM (LoadByte_MEM),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .stall        (stall),
      .ALUOut_WB    (ALUOut_WB),
      .MemData_WB   (MemData_WB),
      .Rw_WB        (Rw_WB),
      .MemtoReg_WB  (MemtoReg_WB),
      .RegWrite_WB  (RegWrite_WB),
      .misalign_err (misalign_err),
      .timeout_err  (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_instr(input logic rd, input logic wr, input logic lb, input logic m2r,
                            input logic rwen, input logic [31:0] addr, input logic [4:0] rw,
                            input logic [31:0] rt);
      MemRead_MEM  = rd;
      MemWrite_MEM = wr;
      LoadByte_MEM = lb;
      MemtoReg_MEM = m2r;
      RegWrite_MEM = rwen;
      ALUOut_MEM   = addr;
      Rw_MEM       = rw;
      rt_MEM       = rt;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 5'd1, 32'h0);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      #12;
      n_total++;
      if (mem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", mem_req);
      else n_pass++;
      n_total++;
      if (stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall);
      else n_pass++;
      n_total++;
      if ({ALUOut_WB, MemData_WB, Rw_WB, MemtoReg_WB, RegWrite_WB, misalign_err, timeout_err}
          !== '0)
         $display("FAIL reset_wb: got %h/%h/%0d/%0b/%0b/%0b/%0b want all 0", ALUOut_WB,
                  MemData_WB, Rw_WB, MemtoReg_WB, RegWrite_WB, misalign_err, timeout_err);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
   endtask

   task automatic test_lw_zero_wait();
      @(negedge clk);
      set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 5'd5, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      #1;
      n_total++;
      if (stall !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10)
         $display("FAIL lw_req: got stall=%0b req=%0b we=%0b addr=%h want 0/1/0/00000010",
                  stall, mem_req, mem_we, mem_addr);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (MemData_WB !== 32'hDEADBEEF || RegWrite_WB !== 1'b1 || Rw_WB !== 5'd5 ||
          MemtoReg_WB !== 1'b1)
         $display("FAIL lw_wb: got data=%h rw_en=%0b rw=%0d m2r=%0b want deadbeef/1/5/1",
                  MemData_WB, RegWrite_WB, Rw_WB, MemtoReg_WB);
      else n_pass++;
   endtask

   task automatic test_lb_wait();
      @(negedge clk);
      set_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h13, 5'd9, 32'h0);
      mem_ready = 1'b0;
      mem_rdata = 32'h80AABBCC;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_total++;
         if (stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h10)
            $display("FAIL lb_stall%0d: got stall=%0b req=%0b addr=%h want 1/1/00000010",
                     i, stall, mem_req, mem_addr);
         else n_pass++;
         @(posedge clk); #1;
         n_total++;
         if (RegWrite_WB !== 1'b0)
            $display("FAIL lb_bubble%0d: got RegWrite_WB=%0b want 0", i, RegWrite_WB);
         else n_pass++;
         @(negedge clk);
      end
      mem_ready = 1'b1;
      #1;
      n_total++;
      if (stall !== 1'b0) $display("FAIL lb_release: got stall=%0b want 0", stall);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (MemData_WB !== 32'hFFFFFF80 || RegWrite_WB !== 1'b1 || Rw_WB !== 5'd9)
         $display("FAIL lb_wb: got data=%h rw_en=%0b rw=%0d want ffffff80/1/9",
                  MemData_WB, RegWrite_WB, Rw_WB);
      else n_pass++;
      // Positive byte from lane 1, zero wait.
      @(negedge clk);
      set_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 5'd10, 32'h0);
      mem_rdata = 32'h80AA7FCC;
      @(posedge clk); #1;
      n_total++;
      if (MemData_WB !== 32'h0000007F)
         $display("FAIL lb_pos: got data=%h want 0000007f", MemData_WB);
      else n_pass++;
   endtask

   task automatic test_misalign();
      @(negedge clk);
      set_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22, 5'd4, 32'h55);
      mem_ready = 1'b0;
      #1;
      n_total++;
      if (mem_req !== 1'b0 || stall !== 1'b0)
         $display("FAIL mis_req: got req=%0b stall=%0b want 0/0", mem_req, stall);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (misalign_err !== 1'b1 || RegWrite_WB !== 1'b0)
         $display("FAIL mis_err: got err=%0b rw_en=%0b want 1/0", misalign_err, RegWrite_WB);
      else n_pass++;
      @(negedge clk);
      set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
      @(posedge clk); #1;
      n_total++;
      if (misalign_err !== 1'b0) $display("FAIL mis_pulse: got err=%0b want 0", misalign_err);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int stalls;
      stalls = 0;
      @(negedge clk);
      set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 5'd6, 32'h0);
      mem_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!stall) break;
         stalls++;
         @(posedge clk);
         @(negedge clk);
      end
      n_total++;
      if (stalls != 15) $display("FAIL to_stalls: got %0d stall cycles want 15", stalls);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (timeout_err !== 1'b1 || RegWrite_WB !== 1'b0)
         $display("FAIL to_err: got err=%0b rw_en=%0b want 1/0", timeout_err, RegWrite_WB);
      else n_pass++;
      @(negedge clk);
      set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 5'd8, 32'h0);
      #1;
      n_total++;
      if (mem_req !== 1'b0 || stall !== 1'b0)
         $display("FAIL to_next_req: got req=%0b stall=%0b want 0/0", mem_req, stall);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (timeout_err !== 1'b0 || RegWrite_WB !== 1'b1 || ALUOut_WB !== 32'h77)
         $display("FAIL to_next_wb: got err=%0b rw_en=%0b alu=%h want 0/1/00000077",
                  timeout_err, RegWrite_WB, ALUOut_WB);
      else n_pass++;
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 5'd7, 32'h0);
      mem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_total++;
      if (stall !== 1'b1) $display("FAIL rw_pre: got stall=%0b want 1", stall);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_total++;
      if (mem_req !== 1'b0 || stall !== 1'b0)
         $display("FAIL rw_async: got req=%0b stall=%0b want 0/0", mem_req, stall);
      else n_pass++;
      n_total++;
      if ({ALUOut_WB, MemData_WB, Rw_WB, MemtoReg_WB, RegWrite_WB} !== '0)
         $display("FAIL rw_wb: got %h/%h/%0d/%0b/%0b want all 0", ALUOut_WB, MemData_WB,
                  Rw_WB, MemtoReg_WB, RegWrite_WB);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      #1;
      n_total++;
      if (stall !== 1'b0 || mem_req !== 1'b1)
         $display("FAIL rw_after: got stall=%0b req=%0b want 0/1", stall, mem_req);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (MemData_WB !== 32'hCAFEF00D || RegWrite_WB !== 1'b1 || Rw_WB !== 5'd7)
         $display("FAIL rw_lw: got data=%h rw_en=%0b rw=%0d want cafef00d/1/7",
                  MemData_WB, RegWrite_WB, Rw_WB);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 5'd3, 32'h0);
      mem_ready = 1'b1;
      #1;
      n_total++;
      if (mem_req !== 1'b0) $display("FAIL b2b_add_req: got req=%0b want 0", mem_req);
      else n_pass++;
      @(negedge clk);
      set_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 5'd0, 32'h12345678);
      #1;
      n_total++;
      if (ALUOut_WB !== 32'h99 || RegWrite_WB !== 1'b1 || Rw_WB !== 5'd3)
         $display("FAIL b2b_add_wb: got alu=%h rw_en=%0b rw=%0d want 00000099/1/3",
                  ALUOut_WB, RegWrite_WB, Rw_WB);
      else n_pass++;
      n_total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h12345678 ||
          mem_addr !== 32'h40 || stall !== 1'b0)
         $display("FAIL b2b_sw_req: got req=%0b we=%0b wd=%h addr=%h stall=%0b want 1/1/12345678/00000040/0",
                  mem_req, mem_we, mem_wdata, mem_addr, stall);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (ALUOut_WB !== 32'h40 || RegWrite_WB !== 1'b0 || MemData_WB !== 32'h0)
         $display("FAIL b2b_sw_wb: got alu=%h rw_en=%0b data=%h want 00000040/0/00000000",
                  ALUOut_WB, RegWrite_WB, MemData_WB);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_lw_zero_wait();
      test_lb_wait();
      test_misalign();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
